// File: rtl/debounce_edge.sv
// ----------------------------------------------------------------------------
// debounce_edge
//
// Purpose:
//   Debounces a raw asynchronous input (switch, push button) and reports
//   the clean level together with one-cycle edge pulses. The raw input is
//   first passed through a flop synchronizer. The debounced level Q follows
//   the synchronized input only after it has disagreed with Q for
//   STABLE_COUNT consecutive enabled cycles.
//
// Parameters:
//   SYNC_STAGES  - synchronizer depth on D_in (2..4)
//   STABLE_COUNT - consecutive mismatch cycles needed to move Q (1..2^CNT_W-1)
//   CNT_W        - stability counter width
//
// Ports:
//   clk   in   rising-edge clock for all state
//   rst_n in   asynchronous active-low reset
//   D_in  in   raw asynchronous input
//   en    in   debounce enable; when low the count is dropped and Q is held
//   Q     out  registered debounced level
//   rise  out  registered one-cycle pulse when Q goes 0->1
//   fall  out  registered one-cycle pulse when Q goes 1->0
//   busy  out  registered, high while the stability counter is nonzero
// ----------------------------------------------------------------------------
module debounce_edge #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 16,
    parameter int CNT_W        = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D_in,
    input  logic en,
    output logic Q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Value of cnt on the cycle where one more mismatch commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             q_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // The synchronizer keeps sampling regardless of en, so that when the
    // block is re-enabled it already sees the current input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Any edge that is disabled, or that sees the synchronized input agree
    // with Q, falls through to the defaults: back to IDLE with an empty
    // count and Q unchanged. Only an enabled mismatch advances the count.
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        q_nxt     = Q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        if (en && (sync_out != Q)) begin
            case (state)
                IDLE: begin
                    if (STABLE_COUNT == 1) begin
                        q_nxt    = sync_out;
                        rise_nxt = sync_out;
                        fall_nxt = ~sync_out;
                    end else begin
                        state_nxt = COUNT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                COUNT: begin
                    if (cnt < CNT_LAST) begin
                        state_nxt = COUNT;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end else begin
                        q_nxt    = sync_out;
                        rise_nxt = sync_out;
                        fall_nxt = ~sync_out;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // busy is derived from the next count so it lines up with cnt itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            Q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Q     <= q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= (cnt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// ----------------------------------------------------------------------------
// tb_debounce_edge
//
// Purpose:
//   Self-checking bench for debounce_edge. Two instances share the same
//   stimulus: one with default parameters and one with STABLE_COUNT=1.
//   Every cycle both are compared with a behavioural model that tracks the
//   synchronizer as a delay queue and the debounce as a run length of
//   consecutive enabled mismatches. A table of spec-derived vectors covers
//   the clean rise/fall, and hand sequences cover the multi-cycle corners.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_debounce_edge;

    localparam int SYNC_STAGES = 2;

    logic clk;
    logic rst_n;
    logic en;
    logic D_in;

    logic q0, rise0, fall0, busy0;
    logic q1, rise1, fall1, busy1;

    int vectors;
    int miscompares;

    logic sawPulse0;
    logic sawPulse1;

    // Model state: delayed synchronizer samples plus per-instance level/run.
    logic hist[$];
    logic mq[2];
    logic mrise[2];
    logic mfall[2];
    int   mrun[2];
    int   msc[2];

    typedef struct {
        logic       d;
        logic [3:0] exp0;
        logic [3:0] exp1;
    } vec_t;

    vec_t vecs[48];

    debounce_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_COUNT(16),
        .CNT_W       (5)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .D_in (D_in),
        .en   (en),
        .Q    (q0),
        .rise (rise0),
        .fall (fall0),
        .busy (busy0)
    );

    debounce_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_COUNT(1),
        .CNT_W       (5)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .D_in (D_in),
        .en   (en),
        .Q    (q1),
        .rise (rise1),
        .fall (fall1),
        .busy (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
        for (int m = 0; m < 2; m++) begin
            mq[m]    = 1'b0;
            mrise[m] = 1'b0;
            mfall[m] = 1'b0;
            mrun[m]  = 0;
        end
    endtask

    // The level seen by the debounce at an edge is the D_in sampled
    // SYNC_STAGES edges earlier. Q moves once the mismatch run reaches the
    // instance's stable count.
    task automatic modelStep();
        logic s;
        if (!rst_n) begin
            modelReset();
        end else begin
            s = hist.pop_front();
            hist.push_back(D_in);
            for (int m = 0; m < 2; m++) begin
                mrise[m] = 1'b0;
                mfall[m] = 1'b0;
                if (!en || (s == mq[m])) begin
                    mrun[m] = 0;
                end else begin
                    mrun[m] = mrun[m] + 1;
                    if (mrun[m] == msc[m]) begin
                        mq[m]    = s;
                        mrise[m] = s;
                        mfall[m] = ~s;
                        mrun[m]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got {Q,rise,fall,busy}=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, sample #1 after the rising edge and
    // compare both instances with the model.
    task automatic applyStimulus(input logic r, input logic e, input logic d);
        @(negedge clk);
        rst_n = r;
        en    = e;
        D_in  = d;
        @(posedge clk);
        #1;
        modelStep();
        if (rise0 || fall0) sawPulse0 = 1'b1;
        if (rise1 || fall1) sawPulse1 = 1'b1;
        checkOutput("model_dut0", {q0, rise0, fall0, busy0}, {mq[0], mrise[0], mfall[0], mrun[0] != 0});
        checkOutput("model_dut1", {q1, rise1, fall1, busy1}, {mq[1], mrise[1], mfall[1], mrun[1] != 0});
    endtask

    initial begin
        int   holdLeft;
        logic rd;
        logic re;
        logic rr;

        vectors     = 0;
        miscompares = 0;
        sawPulse0   = 1'b0;
        sawPulse1   = 1'b0;
        msc[0]      = 16;
        msc[1]      = 1;
        rst_n       = 1'b0;
        en          = 1'b0;
        D_in        = 1'b0;
        modelReset();

        // Clean rise then clean fall, expected values from the latency rule:
        // Q moves after edge 17 (edge 2 for STABLE_COUNT=1), busy on 2..16.
        for (int k = 0; k < 24; k++) begin
            vecs[k].d    = 1'b1;
            vecs[k].exp0 = {k >= 17, k == 17, 1'b0, (k >= 2) && (k <= 16)};
            vecs[k].exp1 = {k >= 2, k == 2, 1'b0, 1'b0};
            vecs[24+k].d    = 1'b0;
            vecs[24+k].exp0 = {k < 17, 1'b0, k == 17, (k >= 2) && (k <= 16)};
            vecs[24+k].exp1 = {k < 2, 1'b0, k == 2, 1'b0};
        end

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_dut0", {q0, rise0, fall0, busy0}, 4'b0000);
        checkOutput("reset_dut1", {q1, rise1, fall1, busy1}, 4'b0000);

        sawPulse0 = 1'b0;
        sawPulse1 = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("release_no_pulse", {2'b00, sawPulse0, sawPulse1}, 4'b0000);

        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, 1'b1, vecs[i].d);
            checkOutput("table_dut0", {q0, rise0, fall0, busy0}, vecs[i].exp0);
            checkOutput("table_dut1", {q1, rise1, fall1, busy1}, vecs[i].exp1);
        end

        // Glitch: five cycles high is far short of the stable count.
        sawPulse0 = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("glitch_no_pulse", {3'b000, sawPulse0}, 4'b0000);
        checkOutput("glitch_end", {q0, rise0, fall0, busy0}, 4'b0000);

        // Enable gating: input toggles while disabled, ending high so the
        // synchronizer already holds 1 when the block is re-enabled.
        sawPulse0 = 1'b0;
        sawPulse1 = 1'b0;
        for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("en_frozen_dut0", {q0, sawPulse0, 1'b0, busy0}, 4'b0000);
        checkOutput("en_frozen_dut1", {q1, sawPulse1, 1'b0, busy1}, 4'b0000);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (k == 15) checkOutput("en_edge15", {q0, rise0, fall0, busy0}, 4'b0001);
            if (k == 16) checkOutput("en_edge16", {q0, rise0, fall0, busy0}, 4'b1100);
        end

        // Reset mid-count: bring Q back to 0, start a rise, reset at cnt=10.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("precount_busy", {q0, rise0, fall0, busy0}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_dut0", {q0, rise0, fall0, busy0}, 4'b0000);
        checkOutput("async_reset_dut1", {q1, rise1, fall1, busy1}, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (k == 16) checkOutput("rst_release_edge16", {q0, rise0, fall0, busy0}, 4'b0001);
            if (k == 17) checkOutput("rst_release_edge17", {q0, rise0, fall0, busy0}, 4'b1100);
        end

        // Randomized bursty input with occasional disable and reset.
        holdLeft = 0;
        rd       = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (holdLeft == 0) begin
                rd       = 1'($urandom_range(0, 1));
                holdLeft = $urandom_range(1, 24);
            end
            holdLeft--;
            re = ($urandom_range(0, 15) != 0);
            rr = ($urandom_range(0, 499) != 0);
            applyStimulus(rr, re, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
